// File: rtl/frame_read_ctrl_if.sv
// Avalon-MM read master and FIFO write-side signals of frame_read_ctrl.
// master = controller side, slave = memory/FIFO side.
interface frame_read_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 9,
  parameter int MEM_AW     = 32
);
  logic [MEM_AW-1:0]     avm_address;
  logic                  avm_read;
  logic [7:0]            avm_burstcount;
  logic                  avm_waitrequest;
  logic [DATA_WIDTH-1:0] avm_readdata;
  logic                  avm_readdatavalid;
  logic [FIFO_AW-1:0]    fifo_used;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;

  modport master (
    output avm_address, avm_read, avm_burstcount, fifo_wr_en, fifo_wr_data,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_used
  );

  modport slave (
    input  avm_address, avm_read, avm_burstcount, fifo_wr_en, fifo_wr_data,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_used
  );
endinterface

// File: rtl/frame_read_ctrl.sv
// Reads a frame of words from Avalon-MM memory in bursts and streams them into a FIFO.
// Define FRAME_READ_ABORT_EN to honour the abort input; otherwise abort is ignored.
module frame_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 9,
  parameter int BURST_LEN  = 16,
  parameter int MEM_AW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW-1:0] frame_base,
  input  logic [23:0]       frame_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  frame_read_ctrl_if.master bus
);
  localparam int DEPTH          = 2**FIFO_AW;
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, FIN} state_t;

  state_t            state, state_nxt;
  logic [MEM_AW-1:0] addr;
  logic [23:0]       remaining;
  logic [7:0]        burst, beat_cnt, burst_calc;
  logic [24:0]       fill_sum;
  logic              fits, last_beat, abort_now, abort_pend;

`ifdef FRAME_READ_ABORT_EN
  assign abort_now = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_now    = 1'b0;
`endif

  // A burst is only issued if every beat fits while keeping the FIFO below full.
  assign burst_calc = (remaining >= 24'(BURST_LEN)) ? 8'(BURST_LEN) : remaining[7:0];
  assign fill_sum   = 25'(bus.fifo_used) + 25'(burst_calc);
  assign fits       = (fill_sum <= 25'(DEPTH - 1));
  assign last_beat  = bus.avm_readdatavalid && (beat_cnt == burst - 8'd1);

  assign bus.avm_address    = addr;
  assign bus.avm_burstcount = burst;
  assign bus.fifo_wr_data   = bus.avm_readdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    bus.avm_read   = 1'b0;
    bus.fifo_wr_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (frame_words != 24'd0) ? CHECK : FIN;
      end
      CHECK: begin
        busy = 1'b1;
        if (remaining == 24'd0 || abort_now) state_nxt = FIN;
        else if (fits)                       state_nxt = REQ;
      end
      REQ: begin
        busy         = 1'b1;
        bus.avm_read = 1'b1;
        if (!bus.avm_waitrequest) state_nxt = DATA;
      end
      DATA: begin
        busy           = 1'b1;
        bus.fifo_wr_en = bus.avm_readdatavalid;
        if (last_beat) state_nxt = (abort_pend || abort_now) ? FIN : CHECK;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and word count advance when a request is accepted, not when its beats land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      remaining  <= '0;
      burst      <= '0;
      beat_cnt   <= '0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start && frame_words != 24'd0) begin
            addr      <= frame_base;
            remaining <= frame_words;
          end
        end
        CHECK: begin
          if (state_nxt == REQ) burst <= burst_calc;
        end
        REQ: begin
          beat_cnt <= '0;
          if (abort_now) abort_pend <= 1'b1;
          if (!bus.avm_waitrequest) begin
            addr      <= addr + MEM_AW'(burst) * MEM_AW'(BYTES_PER_WORD);
            remaining <= remaining - 24'(burst);
          end
        end
        DATA: begin
          if (abort_now) abort_pend <= 1'b1;
          if (bus.avm_readdatavalid) beat_cnt <= beat_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/frame_read_ctrl.md
FRAME_READ_CTRL -- requirements
Module: frame_read_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of memory and FIFO data.
REQ-002 SHALL have parameter FIFO_AW, default 9, FIFO address width; depth DEPTH = 2**FIFO_AW.
REQ-003 SHALL have parameter BURST_LEN, default 16, maximum beats per read burst (power of 2, <= DEPTH/2).
REQ-004 SHALL have parameter MEM_AW, default 32, byte address width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  sole clock; rst  in  1  async active-high reset.
REQ-006 Ports: start in 1 one-cycle frame start; frame_base in MEM_AW byte address; frame_words in 24 word count; abort in 1 stop request.
REQ-007 Ports: busy out 1 frame in progress; done out 1 one-cycle completion pulse.
REQ-008 Ports: fifo_used in FIFO_AW FIFO write-side fill level; fifo_wr_en out 1; fifo_wr_data out DATA_WIDTH.
REQ-009 Ports: avm_address out MEM_AW; avm_read out 1; avm_burstcount out 8; avm_waitrequest in 1; avm_readdata in DATA_WIDTH; avm_readdatavalid in 1.

Function
REQ-010 SHALL implement states IDLE, CHECK, REQ, DATA, FIN.
REQ-011 IDLE: start=1 with frame_words>0 latches base/count, sets busy, -> CHECK; start with frame_words=0 -> FIN without bus activity; start while busy ignored.
REQ-012 CHECK: burst size B = min(BURST_LEN, remaining words); -> REQ only when fifo_used + B <= DEPTH-1, else stay; remaining=0 -> FIN.
REQ-013 REQ: avm_read=1, avm_address=current address, avm_burstcount=B held stable until cycle with avm_waitrequest=0, then -> DATA.
REQ-014 DATA: each avm_readdatavalid beat drives fifo_wr_en=1, fifo_wr_data=avm_readdata same cycle (combinational pass-through, zero latency); after B beats -> CHECK.
REQ-015 At most one burst outstanding; address advances by B*(DATA_WIDTH/8) bytes, wraps modulo 2**MEM_AW.
REQ-016 Controller SHALL never raise FIFO fill above DEPTH-1, so fifo_used (FIFO_AW bits) never aliases full as 0.
REQ-017 readdatavalid outside DATA SHALL be ignored (no FIFO write).
REQ-018 FIN: done=1 for exactly one cycle, busy cleared, -> IDLE; start in FIN ignored.
REQ-019 avm_read SHALL be 0 in every state except REQ.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, avm_read=0, avm_address=0, avm_burstcount=0, fifo_wr_en=0, counters=0.
REQ-021 Reset mid-burst abandons outstanding beats; after release, beats of the abandoned burst are ignored per REQ-017.

Configuration
REQ-022 Macro FRAME_READ_ABORT_EN defined: abort=1 in CHECK -> FIN; in REQ stays until accepted; in REQ/DATA, remaining burst completes (beats still written to FIFO), then FIN instead of CHECK; done pulses.
REQ-023 Macro FRAME_READ_ABORT_EN undefined: abort port present but ignored; frame always runs to completion.

Verification
REQ-024 frame_base=0x1000, frame_words=40, fifo_used=0, no waitrequest -> bursts of 16,16,8 at 0x1000,0x1040,0x1080; 40 fifo_wr_en; one done.
REQ-025 fifo_used=500 held, frame_words=16 -> controller stays in CHECK, avm_read=0; drop fifo_used to 495 -> burst of 16 issued.
REQ-026 avm_waitrequest=1 for 5 cycles in REQ -> address/burstcount/read held stable 6 cycles, single request accepted.
REQ-027 start with frame_words=0 -> done pulse within 2 cycles, no avm_read.
REQ-028 rst asserted after 3 of 16 beats -> all outputs 0 immediately; subsequent late readdatavalid produces no fifo_wr_en.
REQ-029 FRAME_READ_ABORT_EN set, abort during beat 4 of first burst of 64-word frame -> 16 beats written, no second request, done once.
